// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes, display selects, entry FSM states.
// Used by the keypad scanner, key entry controller, ALU and display driver.
package calc_pkg;

    localparam int NDIG_DEFAULT = 4;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    localparam logic [1:0] DISP_A   = 2'd0;
    localparam logic [1:0] DISP_B   = 2'd1;
    localparam logic [1:0] DISP_RES = 2'd2;

    typedef enum logic [2:0] {
        S_A,
        S_OP,
        S_B,
        S_REQ,
        S_DONE
    } state_t;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// One BCD operand register: shifts digits in from the right, suppresses leading
// zeros and reports when all NDIG digit positions are occupied.
module bcd_entry_reg
    import calc_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [3:0]        digit,
    output logic [4*NDIG-1:0] value,
    output logic              full
);

    localparam int CW = $clog2(NDIG + 1);

    logic [CW-1:0] count;

    assign full = (count == CW'(NDIG));

    // clear together with shift_en means "start a fresh operand with this digit"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            if (shift_en && digit != 4'd0) begin
                value <= {{(4*NDIG-4){1'b0}}, digit};
                count <= CW'(1);
            end else begin
                value <= '0;
                count <= '0;
            end
        end else if (shift_en && !full && !(count == '0 && digit == 4'd0)) begin
            value <= {value[4*NDIG-5:0], digit};
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/key_entry_ctrl.sv
// Key entry controller: turns keypad events into two BCD operands and an operator,
// then holds a valid/ready request to the ALU until it is accepted.
module key_entry_ctrl
    import calc_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_press,
    input  logic              is_num,
    input  logic              is_op,
    input  logic              is_eq,
    input  logic [3:0]        num_val,
    input  logic [1:0]        op_val,
    output logic [4*NDIG-1:0] operand_a,
    output logic [4*NDIG-1:0] operand_b,
    output logic [1:0]        op_code,
    output logic              calc_valid,
    input  logic              calc_ready,
    output logic [1:0]        disp_sel,
    output logic              overflow_err
);

    state_t state;
    logic   btn_q;
    logic   evt;
    logic   key_num;
    logic   key_op;
    logic   key_eq;
    logic   a_clear;
    logic   a_shift;
    logic   a_full;
    logic   b_clear;
    logic   b_shift;
    logic   b_full;

    // One event per press, on the first edge that sees the key down
    assign evt     = btn_press & ~btn_q;
    assign key_num = evt & is_num & is_bcd(num_val);
    assign key_op  = evt & ~is_num & is_op & (op_val != OP_NONE);
    assign key_eq  = evt & ~is_num & ~is_op & is_eq;

    always_comb begin
        a_clear = 1'b0;
        a_shift = 1'b0;
        b_clear = 1'b0;
        b_shift = 1'b0;
        case (state)
            S_A: a_shift = key_num;
            S_OP: begin
                b_clear = key_num | key_eq;
                b_shift = key_num;
            end
            S_B: b_shift = key_num;
            S_DONE: begin
                a_clear = key_num;
                a_shift = key_num;
                b_clear = key_num;
            end
            default: ;
        endcase
    end

    bcd_entry_reg #(.NDIG(NDIG)) u_reg_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (a_clear),
        .shift_en (a_shift),
        .digit    (num_val),
        .value    (operand_a),
        .full     (a_full)
    );

    bcd_entry_reg #(.NDIG(NDIG)) u_reg_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (b_clear),
        .shift_en (b_shift),
        .digit    (num_val),
        .value    (operand_b),
        .full     (b_full)
    );

    // Keys are discarded in S_REQ, so the operands stay frozen while calc_valid is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_A;
            btn_q        <= 1'b0;
            op_code      <= OP_NONE;
            calc_valid   <= 1'b0;
            disp_sel     <= DISP_A;
            overflow_err <= 1'b0;
        end else begin
            btn_q <= btn_press;
            case (state)
                S_A: begin
                    if (key_num && a_full) begin
                        overflow_err <= 1'b1;
                    end else if (key_op) begin
                        op_code      <= op_val;
                        disp_sel     <= DISP_A;
                        overflow_err <= 1'b0;
                        state        <= S_OP;
                    end
                end
                S_OP: begin
                    if (key_num) begin
                        disp_sel <= DISP_B;
                        state    <= S_B;
                    end else if (key_op) begin
                        op_code      <= op_val;
                        overflow_err <= 1'b0;
                    end else if (key_eq) begin
                        calc_valid   <= 1'b1;
                        overflow_err <= 1'b0;
                        state        <= S_REQ;
                    end
                end
                S_B: begin
                    if (key_num && b_full) begin
                        overflow_err <= 1'b1;
                    end else if (key_eq) begin
                        calc_valid   <= 1'b1;
                        overflow_err <= 1'b0;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (calc_ready) begin
                        calc_valid <= 1'b0;
                        disp_sel   <= DISP_RES;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (key_num) begin
                        op_code  <= OP_NONE;
                        disp_sel <= DISP_A;
                        state    <= S_A;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed scenarios followed by random key traffic,
// all outputs compared every cycle against a decimal-arithmetic reference model.
module tb_key_entry_ctrl;

    localparam int NDIG    = 4;
    localparam int W       = 4 * NDIG;
    localparam int FULL_AT = 10 ** (NDIG - 1);

    localparam int K_NONE = 0;
    localparam int K_NUM  = 1;
    localparam int K_OP   = 2;
    localparam int K_EQ   = 3;

    localparam int P_A    = 0;
    localparam int P_OP   = 1;
    localparam int P_B    = 2;
    localparam int P_REQ  = 3;
    localparam int P_DONE = 4;

    logic         clk;
    logic         rst_n;
    logic         btn_press;
    logic         is_num;
    logic         is_op;
    logic         is_eq;
    logic [3:0]   num_val;
    logic [1:0]   op_val;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [1:0]   op_code;
    logic         calc_valid;
    logic         calc_ready;
    logic [1:0]   disp_sel;
    logic         overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    int m_a, m_b, m_op, m_valid, m_disp, m_ovf, m_phase;
    bit m_prev;

    key_entry_ctrl #(.NDIG(NDIG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_press    (btn_press),
        .is_num       (is_num),
        .is_op        (is_op),
        .is_eq        (is_eq),
        .num_val      (num_val),
        .op_val       (op_val),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .op_code      (op_code),
        .calc_valid   (calc_valid),
        .calc_ready   (calc_ready),
        .disp_sel     (disp_sel),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic compareAll();
        checkOutput("operand_a", 32'(operand_a), 32'(to_bcd(m_a)));
        checkOutput("operand_b", 32'(operand_b), 32'(to_bcd(m_b)));
        checkOutput("op_code", 32'(op_code), 32'(m_op));
        checkOutput("calc_valid", 32'(calc_valid), 32'(m_valid));
        checkOutput("disp_sel", 32'(disp_sel), 32'(m_disp));
        checkOutput("overflow_err", 32'(overflow_err), 32'(m_ovf));
    endtask

    task automatic modelReset();
        m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_disp = 0; m_ovf = 0;
        m_phase = P_A;
        m_prev = 1'b0;
    endtask

    // Decimal view of an operand: a dropped digit is one that would need NDIG+1 digits
    task automatic modelAppend(inout int v, input int d);
        if (v == 0 && d == 0) begin
        end else if (v >= FULL_AT) begin
            m_ovf = 1;
        end else begin
            v = v * 10 + d;
        end
    endtask

    task automatic modelStep(input bit bp, input int kind, input int val, input bit rdy);
        bit evt, num, op, eq;
        evt = bp && !m_prev;
        m_prev = bp;
        num = evt && kind == K_NUM && val <= 9;
        op  = evt && kind == K_OP && val != 0;
        eq  = evt && kind == K_EQ;
        case (m_phase)
            P_A: begin
                if (num) modelAppend(m_a, val);
                else if (op) begin
                    m_op = val; m_disp = 0; m_ovf = 0; m_phase = P_OP;
                end
            end
            P_OP: begin
                if (num) begin
                    m_b = 0; modelAppend(m_b, val); m_disp = 1; m_phase = P_B;
                end else if (op) begin
                    m_op = val; m_ovf = 0;
                end else if (eq) begin
                    m_b = 0; m_valid = 1; m_ovf = 0; m_phase = P_REQ;
                end
            end
            P_B: begin
                if (num) modelAppend(m_b, val);
                else if (eq) begin
                    m_valid = 1; m_ovf = 0; m_phase = P_REQ;
                end
            end
            P_REQ: begin
                if (rdy) begin
                    m_valid = 0; m_disp = 2; m_phase = P_DONE;
                end
            end
            default: begin
                if (num) begin
                    m_a = 0; m_b = 0; m_op = 0; modelAppend(m_a, val);
                    m_disp = 0; m_phase = P_A;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input bit bp, input int kind, input int val, input bit rdy);
        @(negedge clk);
        btn_press  = bp;
        is_num     = (kind == K_NUM);
        is_op      = (kind == K_OP);
        is_eq      = (kind == K_EQ);
        num_val    = 4'(val);
        op_val     = 2'(val);
        calc_ready = rdy;
        @(posedge clk);
        modelStep(bp, kind, val, rdy);
        #1;
        compareAll();
    endtask

    task automatic pressKey(input int kind, input int val, input int hold);
        repeat (hold) applyStimulus(1'b1, kind, val, 1'b0);
        applyStimulus(1'b0, K_NONE, 0, 1'b0);
    endtask

    // Reset is dropped between edges so its asynchronous effect is observed directly
    task automatic doReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge clk);
        btn_press = 0; is_num = 0; is_op = 0; is_eq = 0;
        num_val = 0; op_val = 0; calc_ready = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        int kind, val, hold;
        rst_n = 1'b1;
        btn_press = 0; is_num = 0; is_op = 0; is_eq = 0;
        num_val = 0; op_val = 0; calc_ready = 0;
        modelReset();
        doReset();

        // Basic calculation with the ALU stalling, then a one-cycle accept
        pressKey(K_NUM, 1, 1);
        pressKey(K_NUM, 2, 2);
        pressKey(K_OP, 1, 1);
        pressKey(K_NUM, 3, 1);
        pressKey(K_EQ, 0, 1);
        checkOutput("req_a", 32'(operand_a), 32'h0012);
        checkOutput("req_b", 32'(operand_b), 32'h0003);
        checkOutput("req_op", 32'(op_code), 32'd1);
        repeat (20) applyStimulus(1'b0, K_NONE, 0, 1'b0);
        checkOutput("req_held", 32'(calc_valid), 32'd1);
        applyStimulus(1'b0, K_NONE, 0, 1'b1);
        checkOutput("hs_valid", 32'(calc_valid), 32'd0);
        checkOutput("hs_disp", 32'(disp_sel), 32'd2);

        // A long hold is still a single digit
        pressKey(K_NUM, 7, 50);
        checkOutput("hold_a", 32'(operand_a), 32'h0007);

        // Reset while a request is pending
        doReset();
        pressKey(K_NUM, 5, 1);
        pressKey(K_OP, 3, 1);
        pressKey(K_EQ, 0, 1);
        doReset();
        checkOutput("rst_valid", 32'(calc_valid), 32'd0);

        pressKey(K_NUM, 0, 1);
        pressKey(K_NUM, 0, 1);
        pressKey(K_NUM, 5, 1);
        checkOutput("lead_zero_a", 32'(operand_a), 32'h0005);

        // Overflow on the fifth digit, cleared by an accepted operator
        doReset();
        for (int d = 1; d <= 5; d++) pressKey(K_NUM, d, 1);
        checkOutput("ovf_a", 32'(operand_a), 32'h1234);
        checkOutput("ovf_set", 32'(overflow_err), 32'd1);
        pressKey(K_OP, 2, 1);
        checkOutput("ovf_clr", 32'(overflow_err), 32'd0);
        pressKey(K_OP, 1, 1);
        pressKey(K_OP, 3, 1);
        checkOutput("op_replace", 32'(op_code), 32'd3);

        doReset();
        pressKey(K_EQ, 0, 1);
        checkOutput("eq_in_a", 32'(calc_valid), 32'd0);
        pressKey(K_NUM, 1, 1);
        pressKey(K_OP, 1, 1);
        pressKey(K_EQ, 0, 1);
        checkOutput("eq_in_op", 32'(calc_valid), 32'd1);
        applyStimulus(1'b0, K_NONE, 0, 1'b1);
        pressKey(K_NUM, 4, 1);
        pressKey(K_OP, 1, 1);
        pressKey(K_NUM, 6, 1);
        pressKey(K_OP, 2, 1);
        checkOutput("no_chain", 32'(op_code), 32'd1);
        pressKey(K_EQ, 0, 1);

        // Key arriving on the accept edge is discarded
        applyStimulus(1'b1, K_NUM, 8, 1'b1);
        applyStimulus(1'b0, K_NONE, 0, 1'b0);
        checkOutput("race_a", 32'(operand_a), 32'h0004);
        checkOutput("race_b", 32'(operand_b), 32'h0006);
        pressKey(K_NUM, 9, 1);
        checkOutput("done_a", 32'(operand_a), 32'h0009);
        checkOutput("done_b", 32'(operand_b), 32'h0000);

        // Random key traffic with a randomly stalling ALU
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) doReset();
            val = $urandom_range(0, 99);
            kind = (val < 50) ? K_NUM : (val < 70) ? K_OP : (val < 85) ? K_EQ : K_NONE;
            val = (kind == K_NUM) ? $urandom_range(0, 11) : $urandom_range(0, 3);
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++)
                applyStimulus(1'b1, kind, val, ($urandom_range(0, 3) == 0));
            for (int g = 0; g < $urandom_range(1, 2); g++)
                applyStimulus(1'b0, $urandom_range(0, 3), $urandom_range(0, 15),
                              ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
